// File: rtl/bubble_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bubble_pkg
//  Description : Shared constants for the bubble page buffer: read-FSM state
//                encoding, default geometry and the idle output level.
//  Revision    : 1.0 - initial release
// ============================================================================
package bubble_pkg;

    // One buffered cell: [1] = odd-loop bit, [0] = even-loop bit
    typedef logic [1:0] cell_t;

    // Read-side FSM state encoding
    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_prefetch = 2'd1;
    localparam logic [1:0] c_st_shift    = 2'd2;
    localparam logic [1:0] c_st_blank    = 2'd3;

    // Default geometry and idle level of the bubble data pins
    localparam int   c_def_addr_w   = 11;
    localparam int   c_def_page_len = 1024;
    localparam logic c_idle_level   = 1'b1;

endpackage : bubble_pkg
`default_nettype wire

// File: rtl/bubble_buffer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : bubble_buffer_bank
//  Description : Simple dual-port RAM holding both ping-pong banks of 2-bit
//                cells. The bank select is the address MSB. Registered read,
//                one cycle of latency; contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module bubble_buffer_bank
    import bubble_pkg::*;
#(
    parameter int ADDR_W = c_def_addr_w
) (
    input  logic            clk,
    input  logic            i_wr_en,
    input  logic [ADDR_W:0] i_wr_addr,
    input  cell_t           i_wr_data,
    input  logic            i_rd_en,
    input  logic [ADDR_W:0] i_rd_addr,
    output cell_t           o_rd_data
);

    localparam int c_depth = 2 ** (ADDR_W + 1);

    cell_t r_mem [0:c_depth-1];
    cell_t r_rd_data;

    // Write port: one cell per enabled cycle
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: registered, holds its value while not enabled
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : bubble_buffer_bank
`default_nettype wire

// File: rtl/bubble_page_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : bubble_page_buffer
//  Description : Ping-pong page buffer between the SPI flash loader and the
//                bubble data pins. The loader fills one bank while the other
//                is shifted out on data_out_strobe; each bank has a full flag
//                that hands it from filler to reader and back.
//                Optional build macro PAGE_BUFFER_UNDERRUN_CNT_EN adds an
//                8-bit saturating underrun_count output.
//  Revision    : 1.0 - initial release
// ============================================================================
module bubble_page_buffer
    import bubble_pkg::*;
#(
    parameter int   ADDR_W     = c_def_addr_w,
    parameter int   PAGE_LEN   = c_def_page_len,
    parameter logic IDLE_LEVEL = c_idle_level
) (
    input  logic              master_clock,
    input  logic              power_good,
    input  logic [ADDR_W-1:0] buf_wr_addr,
    input  logic [1:0]        buf_wr_data,
    input  logic              buf_wr_en,
    input  logic              buf_wr_commit,
    output logic              buf_wr_ready,
    input  logic              data_out_notice,
    input  logic              data_out_strobe,
    output logic              bubble_out_odd,
    output logic              bubble_out_even,
    output logic              page_done,
    output logic              underrun
`ifdef PAGE_BUFFER_UNDERRUN_CNT_EN
    ,
    output logic [7:0]        underrun_count
`endif
);

    // Index of the last cell of a page, and the pointer increment
    localparam int unsigned     c_last_int = PAGE_LEN - 1;
    localparam logic [ADDR_W:0] c_last_idx = c_last_int[ADDR_W:0];
    localparam logic [ADDR_W:0] c_ptr_one  = (ADDR_W + 1)'(1);

    logic [1:0]      r_full;
    logic            r_fill_sel;
    logic            r_read_sel;
    logic [1:0]      r_state;
    logic [ADDR_W:0] r_rd_ptr;
    logic            r_drain_end;
    logic            r_out_odd;
    logic            r_out_even;
    logic            r_page_done;
    logic            r_underrun;

    logic [1:0]      w_full_nxt;
    logic            w_commit;
    logic            w_release;
    logic            w_start;
    logic            w_underrun_evt;
    logic            w_at_last;
    logic            w_wr_en;
    logic [ADDR_W:0] w_wr_addr;
    logic            w_rd_en;
    logic [ADDR_W:0] w_rd_addr;
    cell_t           w_rd_data;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign buf_wr_ready   = ~r_full[r_fill_sel];
    assign w_wr_en        = buf_wr_en & buf_wr_ready;
    assign w_commit       = buf_wr_commit & buf_wr_ready;
    // The bank is handed back one cycle after the last cell was loaded
    assign w_release      = (r_state == c_st_shift) & r_drain_end;
    assign w_start        = (r_state == c_st_idle) & data_out_notice & r_full[r_read_sel];
    assign w_underrun_evt = (r_state == c_st_idle) & data_out_notice & ~r_full[r_read_sel];
    assign w_at_last      = (r_rd_ptr == c_last_idx);

    // RAM addressing: bank select is the MSB; the pointer never crosses banks
    assign w_wr_addr = {r_fill_sel, buf_wr_addr};
    assign w_rd_addr = {r_read_sel, r_rd_ptr[ADDR_W-1:0]};
    assign w_rd_en   = (r_state == c_st_prefetch) | (r_state == c_st_shift);

    // ------------------------------------------------------------------
    // Cell storage for both banks
    // ------------------------------------------------------------------
    bubble_buffer_bank #(
        .ADDR_W    (ADDR_W)
    ) u_bank (
        .clk       (master_clock),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (buf_wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // Next full flags: commit and release touch opposite banks, so both apply
    always_comb begin
        w_full_nxt = r_full;
        if (w_commit) begin
            w_full_nxt[r_fill_sel] = 1'b1;
        end
        if (w_release) begin
            w_full_nxt[r_read_sel] = 1'b0;
        end
    end

    // Fill-side state: bank full flags and the bank the loader is filling
    always_ff @(posedge master_clock) begin
        if (!power_good) begin
            r_full     <= 2'b00;
            r_fill_sel <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_commit) begin
                r_fill_sel <= ~r_fill_sel;
            end
        end
    end

    // Read-side FSM: prefetch, shift a page out, or blank-shift on underrun
    always_ff @(posedge master_clock) begin
        if (!power_good) begin
            r_state     <= c_st_idle;
            r_read_sel  <= 1'b0;
            r_rd_ptr    <= '0;
            r_drain_end <= 1'b0;
            r_out_odd   <= IDLE_LEVEL;
            r_out_even  <= IDLE_LEVEL;
            r_page_done <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_page_done <= 1'b0;
            r_underrun  <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        r_rd_ptr <= '0;
                        r_state  <= c_st_prefetch;
                    end else if (w_underrun_evt) begin
                        r_rd_ptr   <= '0;
                        r_underrun <= 1'b1;
                        r_state    <= c_st_blank;
                    end
                end
                c_st_prefetch: begin
                    // Read of cell 0 is issued this cycle
                    r_state <= c_st_shift;
                end
                c_st_shift: begin
                    if (r_drain_end) begin
                        r_drain_end <= 1'b0;
                        r_read_sel  <= ~r_read_sel;
                        r_page_done <= 1'b1;
                        r_out_odd   <= IDLE_LEVEL;
                        r_out_even  <= IDLE_LEVEL;
                        r_state     <= c_st_idle;
                    end else if (data_out_strobe) begin
                        r_out_odd  <= w_rd_data[1];
                        r_out_even <= w_rd_data[0];
                        r_rd_ptr   <= r_rd_ptr + c_ptr_one;
                        if (w_at_last) begin
                            r_drain_end <= 1'b1;
                        end
                    end
                end
                c_st_blank: begin
                    if (data_out_strobe) begin
                        if (w_at_last) begin
                            r_rd_ptr <= '0;
                            r_state  <= c_st_idle;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + c_ptr_one;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bubble_out_odd  = r_out_odd;
    assign bubble_out_even = r_out_even;
    assign page_done       = r_page_done;
    assign underrun        = r_underrun;

`ifdef PAGE_BUFFER_UNDERRUN_CNT_EN
    logic [7:0] r_underrun_count;

    // Saturating count of underrun events
    always_ff @(posedge master_clock) begin
        if (!power_good) begin
            r_underrun_count <= 8'd0;
        end else if (w_underrun_evt && (r_underrun_count != 8'hFF)) begin
            r_underrun_count <= r_underrun_count + 8'd1;
        end
    end

    assign underrun_count = r_underrun_count;
`endif

endmodule : bubble_page_buffer
`default_nettype wire

// File: tb/tb_bubble_page_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bubble_page_buffer
//  Description : Self-checking bench for bubble_page_buffer. Stimulus pushes
//                expected cells and pulses into queues; a monitor pops and
//                compares them as the DUT presents outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bubble_page_buffer;

    localparam int AW = 11;
`ifdef PAGE_BUFFER_UNDERRUN_CNT_EN
    localparam int PL = 8;
`else
    localparam int PL = 1024;
`endif
    localparam int HALF = (PL > 500) ? 500 : PL / 2;

    logic          master_clock;
    logic          power_good;
    logic [AW-1:0] buf_wr_addr;
    logic [1:0]    buf_wr_data;
    logic          buf_wr_en;
    logic          buf_wr_commit;
    logic          buf_wr_ready;
    logic          data_out_notice;
    logic          data_out_strobe;
    logic          bubble_out_odd;
    logic          bubble_out_even;
    logic          page_done;
    logic          underrun;
`ifdef PAGE_BUFFER_UNDERRUN_CNT_EN
    logic [7:0]    underrun_count;
`endif

    bubble_page_buffer #(
        .ADDR_W          (AW),
        .PAGE_LEN        (PL),
        .IDLE_LEVEL      (1'b1)
    ) dut (
        .master_clock    (master_clock),
        .power_good      (power_good),
        .buf_wr_addr     (buf_wr_addr),
        .buf_wr_data     (buf_wr_data),
        .buf_wr_en       (buf_wr_en),
        .buf_wr_commit   (buf_wr_commit),
        .buf_wr_ready    (buf_wr_ready),
        .data_out_notice (data_out_notice),
        .data_out_strobe (data_out_strobe),
        .bubble_out_odd  (bubble_out_odd),
        .bubble_out_even (bubble_out_even),
        .page_done       (page_done),
        .underrun        (underrun)
`ifdef PAGE_BUFFER_UNDERRUN_CNT_EN
        ,
        .underrun_count  (underrun_count)
`endif
    );

    initial master_clock = 1'b0;
    always #5 master_clock = ~master_clock;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_cell_q[$];
    logic [1:0] exp_pulse_q[$];   // {page_done, underrun}
    bit prev_strobe = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare output cells after each strobe and every pulse seen
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge master_clock);
            if (prev_strobe) begin
                if (exp_cell_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cell: got %b with no expected value queued",
                             {bubble_out_odd, bubble_out_even});
                end else begin
                    e = exp_cell_q.pop_front();
                    check("cell", {30'd0, bubble_out_odd, bubble_out_even}, {30'd0, e});
                end
            end
            if (page_done || underrun) begin
                if (exp_pulse_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pulse: got page_done=%b underrun=%b, none expected",
                             page_done, underrun);
                end else begin
                    e = exp_pulse_q.pop_front();
                    check("pulse", {30'd0, page_done, underrun}, {30'd0, e});
                end
            end
            prev_strobe = data_out_strobe && power_good;
        end
    end

    // Watchdog so the run always ends
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] pat(input int k, input int a);
        logic [31:0] v;
        v = a;
        case (k)
            0:       return v[1:0];
            1:       return ~v[1:0];
            2:       return v[2:1];
            default: return 2'b11;
        endcase
    endfunction

    task automatic tick();
        @(posedge master_clock);
        #1;
    endtask

    task automatic wr(input int a, input logic [1:0] d);
        logic [31:0] v;
        v = a;
        buf_wr_addr = v[AW-1:0];
        buf_wr_data = d;
        buf_wr_en   = 1'b1;
        tick();
        buf_wr_en   = 1'b0;
    endtask

    task automatic fill(input int k);
        for (int a = 0; a < PL; a++) wr(a, pat(k, a));
    endtask

    task automatic commit();
        buf_wr_commit = 1'b1;
        tick();
        buf_wr_commit = 1'b0;
    endtask

    task automatic notice();
        data_out_notice = 1'b1;
        tick();
        data_out_notice = 1'b0;
        tick();
    endtask

    task automatic strobe(input logic [1:0] e);
        exp_cell_q.push_back(e);
        data_out_strobe = 1'b1;
        tick();
        data_out_strobe = 1'b0;
        tick();
    endtask

    task automatic drain(input int k);
        exp_pulse_q.push_back(2'b10);
        for (int a = 0; a < PL; a++) strobe(pat(k, a));
        tick();
    endtask

    task automatic blank_page();
        exp_pulse_q.push_back(2'b01);
        notice();
        for (int a = 0; a < PL; a++) strobe(2'b11);
        tick();
    endtask

    task automatic do_reset();
        power_good = 1'b0;
        tick();
        tick();
        power_good = 1'b1;
        tick();
    endtask

    initial begin
        power_good      = 1'b0;
        buf_wr_addr     = '0;
        buf_wr_data     = 2'b00;
        buf_wr_en       = 1'b0;
        buf_wr_commit   = 1'b0;
        data_out_notice = 1'b0;
        data_out_strobe = 1'b0;
        tick();
        tick();
        tick();
        // Reset state
        check("rst_odd", {31'd0, bubble_out_odd}, 32'd1);
        check("rst_even", {31'd0, bubble_out_even}, 32'd1);
        check("rst_ready", {31'd0, buf_wr_ready}, 32'd1);
        check("rst_pulses", {30'd0, page_done, underrun}, 32'd0);
        power_good = 1'b1;
        tick();

        // 1: fill bank0, drain it in order
        fill(0);
        commit();
        check("t1_ready_after_commit", {31'd0, buf_wr_ready}, 32'd1);
        notice();
        drain(0);
        check("t1_ready", {31'd0, buf_wr_ready}, 32'd1);
        check("t1_idle_out", {30'd0, bubble_out_odd, bubble_out_even}, 32'd3);
        check("t1_pulses_left", exp_pulse_q.size(), 32'd0);

        // 2: notice with both banks empty
        blank_page();
        check("t2_ready", {31'd0, buf_wr_ready}, 32'd1);
        check("t2_pulses_left", exp_pulse_q.size(), 32'd0);

        // 3: both banks full, writes dropped, drain bank0
        do_reset();
        fill(0);
        commit();
        check("t3_ready_one_full", {31'd0, buf_wr_ready}, 32'd1);
        fill(1);
        commit();
        check("t3_ready_both_full", {31'd0, buf_wr_ready}, 32'd0);
        for (int a = 0; a < 4; a++) wr(a, pat(1, a));
        commit();
        notice();
        drain(0);
        check("t3_ready_after_drain", {31'd0, buf_wr_ready}, 32'd1);

        // 4: commit on the same edge as the last-strobe release
        fill(2);
        notice();
        exp_pulse_q.push_back(2'b10);
        for (int a = 0; a < PL - 1; a++) strobe(pat(1, a));
        exp_cell_q.push_back(pat(1, PL - 1));
        data_out_strobe = 1'b1;
        tick();
        data_out_strobe = 1'b0;
        buf_wr_commit   = 1'b1;
        tick();
        buf_wr_commit   = 1'b0;
        tick();
        check("t4_ready", {31'd0, buf_wr_ready}, 32'd1);
        notice();
        drain(2);
        check("t4_ready_after", {31'd0, buf_wr_ready}, 32'd1);
        blank_page();

        // 5: reset mid-page discards both banks
        fill(0);
        commit();
        fill(1);
        commit();
        notice();
        for (int a = 0; a < HALF; a++) strobe(pat(0, a));
        do_reset();
        check("t5_out", {30'd0, bubble_out_odd, bubble_out_even}, 32'd3);
        check("t5_ready", {31'd0, buf_wr_ready}, 32'd1);
        check("t5_pulses", {30'd0, page_done, underrun}, 32'd0);
        blank_page();

`ifdef PAGE_BUFFER_UNDERRUN_CNT_EN
        // 6: saturating underrun counter
        do_reset();
        check("t6_cnt_reset", {24'd0, underrun_count}, 32'd0);
        for (int n = 0; n < 300; n++) blank_page();
        check("t6_cnt_sat", {24'd0, underrun_count}, 32'd255);
`endif

        tick();
        tick();
        check("cells_left", exp_cell_q.size(), 32'd0);
        check("pulses_left", exp_pulse_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bubble_page_buffer
`default_nettype wire
